// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
//   Bundle between the multicycle control FSM and its datapath/memory.
//   master : the controller (consumes op/mem_ready, drives all controls)
//   slave  : the datapath side (drives op/mem_ready, consumes controls)
//   Signals:
//     op[6:0]            opcode field of the instruction register
//     mem_ready          memory handshake, completes an access when mem_req=1
//     mem_req, AdrSrc    memory request / address select (0=PC, 1=ALUOut)
//     IRWrite, PCUpdate  IR load / unconditional PC load
//     Branch[1:0]        00 none, 01 cond branch, 10 JAL, 11 JALR
//     ALUSrcA/B, ALUOp   ALU operand selects and operation class
//     ImmSrc             immediate format (000 I, 001 S, 010 B, 011 J, 100 U)
//     ResultSrc[1:0]     00 ALUOut, 01 mem data, 10 ALU result, 11 Imm
//     RegWrite, MemWrite write enables
//     instr_done         pulse in the last cycle of a retired instruction
//     illegal            high while trapped
//     state[3:0]         debug view of the FSM state
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
  parameter int IMMSRC_W = 3
);
  logic [6:0]          op;
  logic                mem_ready;
  logic                mem_req;
  logic                AdrSrc;
  logic                IRWrite;
  logic                PCUpdate;
  logic [1:0]          Branch;
  logic [1:0]          ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [IMMSRC_W-1:0] ImmSrc;
  logic [1:0]          ResultSrc;
  logic                RegWrite;
  logic                MemWrite;
  logic                instr_done;
  logic                illegal;
  logic [3:0]          state;

  modport master (
    input  op, mem_ready,
    output mem_req, AdrSrc, IRWrite, PCUpdate, Branch, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, ResultSrc, RegWrite, MemWrite, instr_done,
           illegal, state
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, AdrSrc, IRWrite, PCUpdate, Branch, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, ResultSrc, RegWrite, MemWrite, instr_done,
           illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Moore-style control FSM for a multicycle RV32-subset core. Every control
//   output is decoded from the current state; only IRWrite/PCUpdate in FETCH
//   and the completion of the memory states look at mem_ready.
//   Parameters:
//     MEM_WAIT_EN  1: memory states hold until mem_ready; 0: mem_ready ignored
//     TRAP_HALT    1: illegal opcode parks in TRAP until reset; 0: one cycle
//     IMMSRC_W     ImmSrc width (>= 3)
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset (forces IDLE, all outputs 0)
//     bus  master side of multicycle_ctrl_if
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit TRAP_HALT   = 1'b1,
  parameter int IMMSRC_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_ctrl_if.master      bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECR    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_JALR     = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic [3:0] state_q, state_d;
  // Load/store direction captured in DECODE so op is only looked at there.
  logic       is_store_q, is_store_d;
  logic       rdy;

  // With waiting disabled every memory access completes in its first cycle.
  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        is_store_d = (bus.op == OP_STORE);
        case (bus.op)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECR;
          OP_ITYPE:  state_d = S_EXECI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = is_store_q ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (rdy) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB,
      S_BRANCH,
      S_LUI:      state_d = S_FETCH;
      // Jumps write the link register through ALUWB after the PC update.
      S_JAL,
      S_JALR:     state_d = S_ALUWB;
      S_TRAP:     state_d = TRAP_HALT ? S_TRAP : S_FETCH;
      // Encoding 15 (or any corrupted value) recovers through IDLE.
      default:    state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCUpdate   = 1'b0;
    bus.Branch     = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.ImmSrc     = '0;
    bus.ResultSrc  = 2'b00;
    bus.RegWrite   = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 computed during the fetch; IR and PC load only on completion.
        bus.mem_req   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = rdy;
        bus.PCUpdate  = rdy;
      end
      S_DECODE: begin
        // Speculative branch target OldPC + B-imm.
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = IMMSRC_W'(IMM_B);
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = is_store_q ? IMMSRC_W'(IMM_S) : IMMSRC_W'(IMM_I);
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc  = 2'b01;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        // MemWrite stays up through wait cycles; retire only on the handshake.
        bus.mem_req    = 1'b1;
        bus.AdrSrc     = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.instr_done = rdy;
      end
      S_EXECR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b10;
      end
      S_EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 2'b11;
        bus.ImmSrc  = IMMSRC_W'(IMM_I);
      end
      S_ALUWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUOp      = 2'b01;
        bus.Branch     = 2'b01;
        bus.instr_done = 1'b1;
      end
      S_JAL: begin
        // ALU forms OldPC + 4 for the link; target comes via Branch select.
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        bus.ImmSrc   = IMMSRC_W'(IMM_J);
        bus.Branch   = 2'b10;
        bus.PCUpdate = 1'b1;
      end
      S_JALR: begin
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        bus.ImmSrc   = IMMSRC_W'(IMM_I);
        bus.Branch   = 2'b11;
        bus.PCUpdate = 1'b1;
      end
      S_LUI: begin
        bus.ImmSrc     = IMMSRC_W'(IMM_U);
        bus.ResultSrc  = 2'b11;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_TRAP:  bus.illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Two controllers share clock, reset and inputs: dut0 uses TRAP_HALT=1,
//   dut1 uses TRAP_HALT=0. Each instruction is expanded from its class into
//   the list of states it must visit (with chosen fetch/memory wait counts),
//   and every cycle the full control word is compared against the per-state
//   output table. Retirement latency is checked against the latency table.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                 ST_MEMREAD = 4, ST_MEMWB = 5, ST_MEMWRITE = 6, ST_EXECR = 7,
                 ST_EXECI = 8, ST_ALUWB = 9, ST_BRANCH = 10, ST_JAL = 11,
                 ST_JALR = 12, ST_LUI = 13, ST_TRAP = 14;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                         OP_BAD = 7'b1111111;

  typedef struct packed {
    logic       mem_req, adr, irw, pcu;
    logic [1:0] br, srca, srcb, aluop;
    logic [2:0] imm;
    logic [1:0] res;
    logic       regw, memw, done, ill;
    logic [3:0] st;
  } ctl_t;

  typedef struct { int s0; int s1; logic rdy; } step_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0, passed = 0, fails = 0;
  step_t q[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.IMMSRC_W(3)) bus0();
  multicycle_ctrl_if #(.IMMSRC_W(3)) bus1();

  multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .TRAP_HALT(1'b1), .IMMSRC_W(3)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .TRAP_HALT(1'b0), .IMMSRC_W(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  ctl_t o0, o1;
  assign o0 = {bus0.mem_req, bus0.AdrSrc, bus0.IRWrite, bus0.PCUpdate, bus0.Branch,
               bus0.ALUSrcA, bus0.ALUSrcB, bus0.ALUOp, bus0.ImmSrc, bus0.ResultSrc,
               bus0.RegWrite, bus0.MemWrite, bus0.instr_done, bus0.illegal, bus0.state};
  assign o1 = {bus1.mem_req, bus1.AdrSrc, bus1.IRWrite, bus1.PCUpdate, bus1.Branch,
               bus1.ALUSrcA, bus1.ALUSrcB, bus1.ALUOp, bus1.ImmSrc, bus1.ResultSrc,
               bus1.RegWrite, bus1.MemWrite, bus1.instr_done, bus1.illegal, bus1.state};

  // Per-state control table.
  function automatic ctl_t exp_ctl(input int st, input logic [6:0] op, input logic rdy);
    ctl_t c = '0;
    c.st = st[3:0];
    case (st)
      ST_FETCH:    begin c.mem_req = 1; c.srcb = 2; c.res = 2; c.irw = rdy; c.pcu = rdy; end
      ST_DECODE:   begin c.srca = 1; c.srcb = 1; c.imm = 3'b010; end
      ST_MEMADR:   begin c.srca = 2; c.srcb = 1; c.imm = (op == OP_STORE) ? 3'b001 : 3'b000; end
      ST_MEMREAD:  begin c.mem_req = 1; c.adr = 1; end
      ST_MEMWB:    begin c.res = 1; c.regw = 1; c.done = 1; end
      ST_MEMWRITE: begin c.mem_req = 1; c.adr = 1; c.memw = 1; c.done = rdy; end
      ST_EXECR:    begin c.srca = 2; c.srcb = 0; c.aluop = 2; end
      ST_EXECI:    begin c.srca = 2; c.srcb = 1; c.aluop = 3; c.imm = 3'b000; end
      ST_ALUWB:    begin c.res = 0; c.regw = 1; c.done = 1; end
      ST_BRANCH:   begin c.srca = 2; c.aluop = 1; c.br = 1; c.done = 1; end
      ST_JAL:      begin c.srca = 1; c.srcb = 2; c.imm = 3'b011; c.br = 2; c.pcu = 1; end
      ST_JALR:     begin c.srca = 1; c.srcb = 2; c.imm = 3'b000; c.br = 3; c.pcu = 1; end
      ST_LUI:      begin c.imm = 3'b100; c.res = 3; c.regw = 1; c.done = 1; end
      ST_TRAP:     c.ill = 1;
      default:     ;
    endcase
    return c;
  endfunction

  // Zero-wait latency from FETCH entry to retirement.
  function automatic int base_lat(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_STORE, OP_JAL, OP_JALR: return 4;
      OP_LOAD:                               return 5;
      OP_BR, OP_LUI:                         return 3;
      default:                               return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input int s, input logic rdy);
    step_t t;
    t.s0 = s; t.s1 = s; t.rdy = rdy;
    q.push_back(t);
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its state walk; w fetch waits, m memory waits.
  task automatic gen(input logic [6:0] op, input int w, input int m);
    q.delete();
    for (int i = 0; i < w; i++) push(ST_FETCH, 1'b0);
    push(ST_FETCH, 1'b1);
    push(ST_DECODE, rnd());
    case (op)
      OP_LOAD: begin
        push(ST_MEMADR, rnd());
        for (int i = 0; i < m; i++) push(ST_MEMREAD, 1'b0);
        push(ST_MEMREAD, 1'b1);
        push(ST_MEMWB, rnd());
      end
      OP_STORE: begin
        push(ST_MEMADR, rnd());
        for (int i = 0; i < m; i++) push(ST_MEMWRITE, 1'b0);
        push(ST_MEMWRITE, 1'b1);
      end
      OP_R:    begin push(ST_EXECR, rnd()); push(ST_ALUWB, rnd()); end
      OP_I:    begin push(ST_EXECI, rnd()); push(ST_ALUWB, rnd()); end
      OP_BR:   push(ST_BRANCH, rnd());
      OP_JAL:  begin push(ST_JAL, rnd()); push(ST_ALUWB, rnd()); end
      OP_JALR: begin push(ST_JALR, rnd()); push(ST_ALUWB, rnd()); end
      OP_LUI:  push(ST_LUI, rnd());
      default: ;
    endcase
  endtask

  task automatic drive(input logic [6:0] op, input logic rdy);
    bus0.op = op; bus1.op = op;
    bus0.mem_ready = rdy; bus1.mem_ready = rdy;
  endtask

  // Replay the queue cycle by cycle; lat>0 also checks retirement latency.
  task automatic play(input logic [6:0] op, input int lat, input string tag);
    int seen = 0;
    foreach (q[i]) begin
      @(negedge clk);
      drive(op, q[i].rdy);
      #1;
      chk({tag, "/dut0"}, 32'(o0), 32'(exp_ctl(q[i].s0, op, q[i].rdy)));
      chk({tag, "/dut1"}, 32'(o1), 32'(exp_ctl(q[i].s1, op, q[i].rdy)));
      if (seen == 0 && o0.done) seen = i + 1;
    end
    if (lat > 0) chk({tag, "/latency"}, 32'(seen), 32'(lat));
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    drive(OP_R, 1'b1);
    #1;
    chk({tag, "/idle0"}, 32'(o0), 32'(exp_ctl(ST_IDLE, OP_R, 1'b1)));
    chk({tag, "/idle1"}, 32'(o1), 32'(exp_ctl(ST_IDLE, OP_R, 1'b1)));
  endtask

  task automatic run(input logic [6:0] op, input int w, input int m, input string tag);
    int mw;
    mw = (op == OP_LOAD || op == OP_STORE) ? m : 0;
    gen(op, w, m);
    play(op, base_lat(op) + w + mw, tag);
  endtask

  initial begin
    logic [6:0] ops [8];
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    drive(OP_R, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_hold0", 32'(o0), 32'(ctl_t'('0)));
    chk("reset_hold1", 32'(o1), 32'(ctl_t'('0)));

    // R-type straight out of reset: IDLE, FETCH, DECODE, EXECR, ALUWB, repeat.
    release_reset("rel");
    run(OP_R, 0, 0, "rtype");
    run(OP_R, 0, 0, "rtype_again");
    // Load with two MEMREAD wait cycles.
    run(OP_LOAD, 0, 2, "load_wait2");
    // Store, zero wait.
    run(OP_STORE, 0, 0, "store");
    // JAL then BEQ.
    run(OP_JAL, 0, 0, "jal");
    run(OP_BR, 0, 0, "beq");
    run(OP_JALR, 1, 0, "jalr_fwait");
    run(OP_LUI, 0, 0, "lui");
    run(OP_I, 2, 0, "itype_fwait");
    run(OP_STORE, 1, 3, "store_wait3");

    // Randomized instruction mix with random fetch/memory waits.
    for (int n = 0; n < 60; n++) begin
      int k, w, m;
      k = $urandom_range(0, 7);
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      m = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      run(ops[k], w, m, "rand");
    end

    // Illegal opcode: dut0 parks in TRAP, dut1 traps for one cycle then refetches.
    q.delete();
    push(ST_FETCH, 1'b1);
    push(ST_DECODE, rnd());
    for (int r = 0; r < 3; r++) begin
      step_t t;
      t.s0 = ST_TRAP; t.s1 = ST_TRAP;   t.rdy = rnd(); q.push_back(t);
      t.s0 = ST_TRAP; t.s1 = ST_FETCH;  t.rdy = 1'b1;  q.push_back(t);
      t.s0 = ST_TRAP; t.s1 = ST_DECODE; t.rdy = rnd(); q.push_back(t);
    end
    play(OP_BAD, 0, "trap");

    // Reset pulse in the middle of a MEMWRITE wait.
    rst = 1'b1;
    @(negedge clk);
    release_reset("rel2");
    gen(OP_STORE, 0, 2);
    void'(q.pop_back());
    play(OP_STORE, 0, "st_wait");
    @(negedge clk);
    drive(OP_STORE, 1'b0);
    #1;
    chk("st_wait_memw", 32'(o0), 32'(exp_ctl(ST_MEMWRITE, OP_STORE, 1'b0)));
    #2 rst = 1'b1;
    #1;
    chk("rst_async0", 32'(o0), 32'(ctl_t'('0)));
    chk("rst_async1", 32'(o1), 32'(ctl_t'('0)));
    release_reset("rel3");
    run(OP_R, 0, 0, "after_rst");
    run(OP_LOAD, 1, 1, "after_rst_ld");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1, meaning 1 = memory states hold until mem_ready and 0 = mem_ready ignored (treated as 1).
REQ-002 Parameter TRAP_HALT, default 1, meaning 1 = illegal opcode parks the FSM in TRAP until reset and 0 = TRAP lasts one cycle, then FETCH.
REQ-003 Parameter IMMSRC_W, default 3, meaning ImmSrc width (>=3).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 op  input  7  opcode field of the instruction register, sampled only in DECODE.
REQ-007 mem_ready  input  1  memory handshake; the access completes in a cycle where mem_req=1 and mem_ready=1.
REQ-008 mem_req  output  1  memory access request.
REQ-009 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 IRWrite  output  1  instruction register load enable.
REQ-011 PCUpdate  output  1  unconditional PC load enable.
REQ-012 Branch  output  2  00 = none, 01 = conditional branch, 10 = JAL, 11 = JALR.
REQ-013 ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1.
REQ-014 ALUSrcB  output  2  00 = RD2, 01 = Imm, 10 = constant 4.
REQ-015 ALUOp  output  2  00 = add, 01 = subtract/compare, 10 = R-type funct decode, 11 = I-type funct decode.
REQ-016 ImmSrc  output  IMMSRC_W  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
REQ-017 ResultSrc  output  2  00 = ALUOut, 01 = memory data, 10 = ALU result, 11 = Imm.
REQ-018 RegWrite, MemWrite  output  1 each  register file write enable and memory write enable.
REQ-019 instr_done  output  1  one-cycle pulse in the final cycle of every retired instruction.
REQ-020 illegal  output  1  asserted while in TRAP.
REQ-021 state  output  4  current state encoding, for debug.

Function
REQ-022 All outputs shall be Moore outputs, decoded from state only, except IRWrite/PCUpdate in FETCH and the exit of the memory states, which are additionally gated by mem_ready.
REQ-023 States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECR=7, EXECI=8, ALUWB=9, BRANCH=10, JAL=11, JALR=12, LUI=13, TRAP=14.
REQ-024 Any output not listed for a state shall be 0.
REQ-025 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-026 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=PCUpdate=mem_ready; go to DECODE when mem_ready, else stay.
REQ-027 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc=B.
REQ-028 DECODE next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other -> TRAP
REQ-029 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc=S if op=0100011 else I; next state MEMWRITE for a store, MEMREAD for a load.
REQ-030 MEMREAD: mem_req=1, AdrSrc=1; go to MEMWB on mem_ready, else stay.
REQ-031 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1; next state FETCH.
REQ-032 MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1; instr_done=mem_ready; go to FETCH on mem_ready, else stay with MemWrite held.
REQ-033 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-034 EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=11, ImmSrc=I; next state ALUWB.
REQ-035 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1; next state FETCH.
REQ-036 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=01, instr_done=1; next state FETCH.
REQ-037 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ImmSrc=J, Branch=10, PCUpdate=1; next state ALUWB.
REQ-038 JALR: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ImmSrc=I, Branch=11, PCUpdate=1; next state ALUWB.
REQ-039 LUI: ImmSrc=U, ResultSrc=11, RegWrite=1, instr_done=1; next state FETCH.
REQ-040 TRAP: illegal=1, all enables 0; stay in TRAP if TRAP_HALT=1, else go to FETCH next cycle.
REQ-041 Latency with zero wait states, in cycles from FETCH entry to the instr_done cycle inclusive: R/I 4, load 5, store 4, branch 3, JAL/JALR 4, LUI 3.
REQ-042 Each memory wait cycle shall add exactly 1 cycle; no request shall be dropped and outputs shall stay stable while waiting.
REQ-043 mem_ready arriving while mem_req=0 shall be ignored.
REQ-044 Unused state encodings 15 and any illegal encoding shall transition to IDLE.

Reset
REQ-045 While rst=1, state shall be IDLE immediately (asynchronously), so all outputs are 0.
REQ-046 Reset asserted mid-instruction, including during a MEMWRITE wait, shall deassert MemWrite and mem_req in the same cycle, with no completion pulse.
REQ-047 After rst falls, the FSM shall spend 1 cycle in IDLE, then enter FETCH.

Verification
REQ-048 Reset release, mem_ready=1, op=0110011 -> states 0,1,2,7,9; RegWrite=1 and instr_done=1 in cycle 5 after release; repeats from FETCH.
REQ-049 Load, op=0000011, mem_ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles with mem_req=1 and AdrSrc=1; MEMWB follows with ResultSrc=01; total latency 7.
REQ-050 Store, op=0100011, mem_ready=1 -> MEMADR shows ImmSrc=001; MEMWRITE shows MemWrite=1 and instr_done=1 for exactly 1 cycle.
REQ-051 JAL then BEQ -> JAL state shows Branch=10 and PCUpdate=1, then ALUWB writes with ResultSrc=00; BEQ completes in 3 cycles with Branch=01 and ALUOp=01.
REQ-052 op=1111111 -> TRAP with illegal=1 held indefinitely (TRAP_HALT=1); with TRAP_HALT=0, illegal pulses 1 cycle, then FETCH.
REQ-053 rst pulsed during MEMWRITE wait -> MemWrite=0 asynchronously; after release IDLE for 1 cycle, then FETCH.
